// File: rtl/conv_window_scheduler.sv
// ============================================================================
//  Module      : conv_window_scheduler
//  Description : Streams a frame through two line buffers, issues each 3x3
//                window to the MAC array and returns the sums on AXI4-Stream.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module conv_window_scheduler #(
    parameter int DATA_W    = 16,
    parameter int SUM_W     = 32,
    parameter int MAX_WIDTH = 64
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  cfg_enable,
    input  logic [15:0]           cfg_width,
    input  logic [15:0]           cfg_height,
    output logic                  cfg_err,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_W-1:0]     s_axis_data,
    input  logic                  s_axis_last,
    output logic [9*DATA_W-1:0]   win_data,
    output logic                  win_start,
    input  logic                  acc_ready,
    input  logic [SUM_W-1:0]      acc_sum,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [SUM_W-1:0]      m_axis_data,
    output logic                  m_axis_last,
    output logic                  busy,
    output logic                  err_last
);

    localparam int C_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_w;
    logic [15:0]         r_h;
    logic [15:0]         r_col;
    logic [15:0]         r_row;
    logic [31:0]         r_res_cnt;
    logic [31:0]         r_total;
    logic [DATA_W-1:0]   r_win [9];
    logic [DATA_W-1:0]   r_lb0 [MAX_WIDTH];
    logic [DATA_W-1:0]   r_lb1 [MAX_WIDTH];
    logic [SUM_W-1:0]    r_out_data;
    logic                r_out_last;
    logic                r_cfg_err;
    logic                r_err_last;

    logic                w_cfg_ok;
    logic                w_accept;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_win_done;
    logic [31:0]         w_total;
    logic [C_AW-1:0]     w_lb_idx;

    assign w_cfg_ok   = (cfg_width >= 16'd3) && ({16'd0, cfg_width} <= 32'(MAX_WIDTH))
                        && (cfg_height >= 16'd3);
    assign w_total    = ({16'd0, cfg_width} - 32'd2) * ({16'd0, cfg_height} - 32'd2);
    assign w_accept   = (r_state == S_STREAM) && s_axis_valid;
    assign w_col_last = (r_col == r_w - 16'd1);
    assign w_row_last = (r_row == r_h - 16'd1);
    assign w_win_done = w_accept && (r_row >= 16'd2) && (r_col >= 16'd2);
    assign w_lb_idx   = r_col[C_AW-1:0];

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        s_axis_ready = 1'b0;
        win_start    = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (cfg_enable && w_cfg_ok) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                s_axis_ready = 1'b1;
                if (w_win_done) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                win_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (acc_ready) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                m_axis_valid = 1'b1;
                m_axis_last  = r_out_last;
                if (m_axis_ready) begin
                    w_next = r_out_last ? S_IDLE : S_STREAM;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_w        <= 16'd0;
            r_h        <= 16'd0;
            r_col      <= 16'd0;
            r_row      <= 16'd0;
            r_res_cnt  <= 32'd0;
            r_total    <= 32'd0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_err_last <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            if ((r_state == S_IDLE) && cfg_enable) begin
                if (w_cfg_ok) begin
                    r_w       <= cfg_width;
                    r_h       <= cfg_height;
                    r_col     <= 16'd0;
                    r_row     <= 16'd0;
                    r_res_cnt <= 32'd0;
                    r_total   <= w_total;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end
            if (w_accept) begin
                // Window slides left; new right column is {lb1, lb0, pixel}.
                for (int k = 0; k < 3; k++) begin
                    r_win[3*k]   <= r_win[3*k+1];
                    r_win[3*k+1] <= r_win[3*k+2];
                end
                r_win[2] <= r_lb1[w_lb_idx];
                r_win[5] <= r_lb0[w_lb_idx];
                r_win[8] <= s_axis_data;
                if (w_col_last) begin
                    r_col <= 16'd0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
                if (s_axis_last && !(w_col_last && w_row_last)) begin
                    r_err_last <= 1'b1;
                end
            end
            if ((r_state == S_WAIT) && acc_ready) begin
                r_out_data <= acc_sum;
                r_out_last <= (r_res_cnt + 32'd1 == r_total);
                r_res_cnt  <= r_res_cnt + 32'd1;
            end
        end
    end

    // Line buffers carry no reset: every entry is rewritten before it feeds a window.
    always_ff @(posedge axi_clk) begin
        if (w_accept) begin
            r_lb1[w_lb_idx] <= r_lb0[w_lb_idx];
            r_lb0[w_lb_idx] <= s_axis_data;
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_slot
        assign win_data[k*DATA_W +: DATA_W] = r_win[k];
    end

    assign m_axis_data = r_out_data;
    assign cfg_err     = r_cfg_err;
    assign err_last    = r_err_last;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
// ============================================================================
//  Module      : tb_conv_window_scheduler
//  Description : Self-checking bench with a latency-4 accelerator model and a
//                result scoreboard. Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_window_scheduler;

    localparam int DATA_W    = 16;
    localparam int SUM_W     = 32;
    localparam int MAX_WIDTH = 64;

    logic                axi_clk      = 1'b0;
    logic                axi_reset_n  = 1'b0;
    logic                cfg_enable   = 1'b0;
    logic [15:0]         cfg_width    = 16'd0;
    logic [15:0]         cfg_height   = 16'd0;
    logic                cfg_err;
    logic                s_axis_valid = 1'b0;
    logic                s_axis_ready;
    logic [DATA_W-1:0]   s_axis_data  = '0;
    logic                s_axis_last  = 1'b0;
    logic [9*DATA_W-1:0] win_data;
    logic                win_start;
    logic                acc_ready    = 1'b0;
    logic [SUM_W-1:0]    acc_sum      = '0;
    logic                m_axis_valid;
    logic                m_axis_ready = 1'b0;
    logic [SUM_W-1:0]    m_axis_data;
    logic                m_axis_last;
    logic                busy;
    logic                err_last;

    conv_window_scheduler #(
        .DATA_W    (DATA_W),
        .SUM_W     (SUM_W),
        .MAX_WIDTH (MAX_WIDTH)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .cfg_enable   (cfg_enable),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_err      (cfg_err),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .win_data     (win_data),
        .win_start    (win_start),
        .acc_ready    (acc_ready),
        .acc_sum      (acc_sum),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .busy         (busy),
        .err_last     (err_last)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [SUM_W-1:0] data;
        logic             last;
    } exp_t;

    typedef struct {
        int   w;
        int   h;
        logic exp_err;
        logic exp_busy;
    } cfg_vec_t;

    exp_t     tbl5 [9];
    cfg_vec_t ct   [4];
    exp_t     sb_q [$];
    exp_t     mon_e;

    int   checks       = 0;
    int   failures     = 0;
    int   bp_cycles    = 0;
    int   hold_cnt     = 0;
    int   post_hs      = 0;
    logic prev_hold    = 1'b0;
    logic [SUM_W-1:0] prev_data = '0;
    logic exp_err_last = 1'b0;

    int               acc_cnt  = 0;
    logic [SUM_W-1:0] acc_hold = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout/none expected event at %0t", name, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {57'd0, s_axis_ready, win_start, m_axis_valid, m_axis_last,
                               busy, cfg_err, err_last}, 64'd0);
        check({tag, "_win_data_zero"}, 64'(win_data == '0), 64'd1);
        check({tag, "_m_data"}, 64'(m_axis_data), 64'd0);
    endtask

    // Accelerator model: sums the 9 slots, answers four cycles after the start.
    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            acc_cnt   = 0;
            acc_ready = 1'b0;
        end else begin
            acc_ready = 1'b0;
            acc_sum   = $urandom;
            if (acc_cnt > 0) begin
                acc_cnt--;
                if (acc_cnt == 0) begin
                    acc_ready = 1'b1;
                    acc_sum   = acc_hold;
                end
            end
            if (win_start) begin
                acc_hold = '0;
                for (int k = 0; k < 9; k++) begin
                    acc_hold += SUM_W'(win_data[k*DATA_W +: DATA_W]);
                end
                acc_cnt = 4;
            end
        end
    end

    // Output sink with optional back-pressure; pops the scoreboard on each handshake.
    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            m_axis_ready = 1'b0;
            hold_cnt     = 0;
            post_hs      = 0;
            prev_hold    = 1'b0;
        end else begin
            if (post_hs == 1) begin
                check("idle_after_last", 64'(busy), 64'd0);
            end else if (post_hs == 2) begin
                check("s_ready_after_out", 64'(s_axis_ready), 64'd1);
            end
            post_hs = 0;
            if (m_axis_valid) begin
                check("no_stream_during_out", 64'(s_axis_ready), 64'd0);
                if (prev_hold) begin
                    check("out_data_stable", 64'(m_axis_data), 64'(prev_data));
                end
                if (hold_cnt >= bp_cycles) begin
                    m_axis_ready = 1'b1;
                    hold_cnt     = 0;
                    prev_hold    = 1'b0;
                    if (sb_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("result_data", 64'(m_axis_data), 64'(mon_e.data));
                        check("result_last", 64'(m_axis_last), 64'(mon_e.last));
                        post_hs = mon_e.last ? 1 : 2;
                    end
                end else begin
                    m_axis_ready = 1'b0;
                    hold_cnt++;
                    prev_hold = 1'b1;
                    prev_data = m_axis_data;
                end
            end else begin
                m_axis_ready = 1'b0;
                prev_hold    = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge axi_clk);
        axi_reset_n = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge axi_clk);
        axi_reset_n = 1'b1;
    endtask

    // mode 0: pixel = r*w+c, results from tbl5; mode 1: pixel = column index.
    task automatic run_frame(input int w, input int h, input int mode,
                             input int last_at, input int abort_at);
        int   n;
        int   idx;
        exp_t e;
        @(negedge axi_clk);
        cfg_width  = 16'(w);
        cfg_height = 16'(h);
        cfg_enable = 1'b1;
        @(negedge axi_clk);
        check("start_ready", 64'(s_axis_ready), 64'd1);
        cfg_enable = 1'b0;
        cfg_width  = 16'd2;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                s_axis_valid = 1'b1;
                s_axis_data  = (mode == 0) ? 16'(r*w + c) : 16'(c);
                s_axis_last  = ((r*w + c) == last_at);
                idx = -1;
                if (r >= 2 && c >= 2) begin
                    idx = (r-2)*(w-2) + (c-2);
                    if (mode == 0) begin
                        e = tbl5[idx];
                    end else begin
                        e.data = SUM_W'(3*(3*idx + 3));
                        e.last = (idx == (w-2)*(h-2) - 1);
                    end
                    sb_q.push_back(e);
                end
                n = 0;
                while (!s_axis_ready && n < 200) begin
                    @(negedge axi_clk);
                    n++;
                end
                if (n >= 200) begin
                    fail_now("pixel_accept_timeout");
                    s_axis_valid = 1'b0;
                    return;
                end
                @(negedge axi_clk);
                s_axis_valid = 1'b0;
                s_axis_last  = 1'b0;
                if (idx >= 0) begin
                    check("win_start_after_window", 64'(win_start), 64'd1);
                    check("ready_drops_at_issue", 64'(s_axis_ready), 64'd0);
                    if (idx + 1 == abort_at) begin
                        @(negedge axi_clk);
                        #2 axi_reset_n = 1'b0;
                        #1 check_all_zero("async_reset");
                        sb_q.delete();
                        @(negedge axi_clk);
                        @(negedge axi_clk);
                        axi_reset_n = 1'b1;
                        return;
                    end
                end
            end
        end
        n = 0;
        while (busy && n < 2000) begin
            @(negedge axi_clk);
            n++;
        end
        check("frame_end_busy", 64'(busy), 64'd0);
        check("all_results_seen", 64'(sb_q.size()), 64'd0);
        check("cfg_err_clear", 64'(cfg_err), 64'd0);
        check("err_last", 64'(err_last), 64'(exp_err_last));
        check("ready_idle", 64'(s_axis_ready), 64'd0);
    endtask

    initial begin
        int v [9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
        for (int i = 0; i < 9; i++) begin
            tbl5[i].data = SUM_W'(v[i]);
            tbl5[i].last = (i == 8);
        end
        ct[0] = '{w: 2,  h: 5, exp_err: 1'b1, exp_busy: 1'b0};
        ct[1] = '{w: 65, h: 5, exp_err: 1'b1, exp_busy: 1'b0};
        ct[2] = '{w: 5,  h: 2, exp_err: 1'b1, exp_busy: 1'b0};
        ct[3] = '{w: 3,  h: 3, exp_err: 1'b0, exp_busy: 1'b1};

        repeat (3) @(negedge axi_clk);
        check_all_zero("reset");
        axi_reset_n = 1'b1;

        run_frame(5, 5, 0, 24, 0);
        bp_cycles = 5;
        run_frame(5, 5, 0, 24, 0);
        bp_cycles = 0;
        run_frame(64, 3, 1, -1, 0);
        exp_err_last = 1'b1;
        run_frame(5, 5, 0, 7, 0);
        run_frame(5, 5, 0, 24, 3);
        exp_err_last = 1'b0;
        run_frame(5, 5, 0, 24, 0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            @(negedge axi_clk);
            cfg_width  = 16'(ct[i].w);
            cfg_height = 16'(ct[i].h);
            cfg_enable = 1'b1;
            repeat (2) begin
                @(negedge axi_clk);
                check("cfg_s_ready", 64'(s_axis_ready), 64'(ct[i].exp_busy));
            end
            cfg_enable = 1'b0;
            check("cfg_err_flag", 64'(cfg_err), 64'(ct[i].exp_err));
            check("cfg_busy", 64'(busy), 64'(ct[i].exp_busy));
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
